// File: rtl/fp32_serial_host.sv
// Host side of the fp32 adder serial link.
// Takes an operand pair over valid/ready, resets and arms the adder core,
// shifts A then B out MSB-first on add_sdi, then collects the 32-bit result
// from add_sdo while add_done is high. Status and data are returned over
// valid/ready. Only one operation is in flight at a time.
// Every output is registered: each output register is loaded from the value
// that belongs to the state being entered, so the outputs line up with the
// state that is actually active.
module fp32_serial_host #(
  parameter int RST_CYCLES = 2,
  parameter int ARM_CYCLES = 2,
  parameter int LEAD       = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_status,
  output logic        add_rst,
  output logic        add_go,
  output logic        add_sdi,
  input  logic        add_sdo,
  input  logic        add_done,
  input  logic        add_over,
  input  logic        add_under
);

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_OVER  = 2'b01;
  localparam logic [1:0] ST_UNDER = 2'b10;
  localparam logic [1:0] ST_TMO   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_ARM, S_GO, S_SEND, S_WAIT, S_RECV, S_RESP
  } state_t;

  state_t      r_state, w_state_next;
  logic [6:0]  r_bit_cnt;
  logic [3:0]  r_lead_cnt;
  logic [15:0] r_tmo_cnt;
  logic [63:0] r_shreg;
  logic [30:0] r_res;

  logic        r_req_ready, r_rsp_valid, r_add_rst, r_add_go, r_add_sdi;
  logic [31:0] r_rsp_data;
  logic [1:0]  r_rsp_status;

  logic        w_req_ready_next, w_rsp_valid_next, w_add_rst_next, w_add_go_next, w_add_sdi_next;
  logic [31:0] w_rsp_data_next;
  logic [1:0]  w_rsp_status_next;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state decision
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid && r_req_ready) w_state_next = S_RST;
      S_RST:  if (r_tmo_cnt == 16'(RST_CYCLES - 1)) w_state_next = S_ARM;
      S_ARM:  if (r_tmo_cnt == 16'(ARM_CYCLES - 1)) w_state_next = (LEAD == 0) ? S_SEND : S_GO;
      S_GO:   if (r_lead_cnt == 4'(LEAD - 1)) w_state_next = S_SEND;
      S_SEND: if (r_bit_cnt == 7'd63) w_state_next = S_WAIT;
      S_WAIT: begin
        // A done in the final waiting cycle still beats the timeout.
        if (add_done) w_state_next = (add_over || add_under) ? S_RESP : S_RECV;
        else if (r_tmo_cnt == 16'(TIMEOUT - 1)) w_state_next = S_RESP;
      end
      S_RECV: if (!add_done || r_bit_cnt == 7'd30) w_state_next = S_RESP;
      S_RESP: if (rsp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output values for the cycle that follows this clock edge
  always_comb begin
    w_req_ready_next  = (w_state_next == S_IDLE);
    w_rsp_valid_next  = (w_state_next == S_RESP);
    w_add_rst_next    = (w_state_next == S_RST) || (w_state_next == S_RESP);
    w_add_go_next     = (w_state_next == S_IDLE) || (w_state_next == S_RST) || (w_state_next == S_ARM);
    w_add_sdi_next    = (w_state_next == S_SEND) ? r_shreg[63] : 1'b0;
    w_rsp_status_next = r_rsp_status;
    w_rsp_data_next   = r_rsp_data;
    case (r_state)
      S_WAIT: if (w_state_next == S_RESP) begin
        w_rsp_data_next = '0;
        if (add_done && add_over)       w_rsp_status_next = ST_OVER;
        else if (add_done && add_under) w_rsp_status_next = ST_UNDER;
        else                            w_rsp_status_next = ST_TMO;
      end
      S_RECV: if (w_state_next == S_RESP) begin
        if (add_done) begin
          w_rsp_status_next = ST_OK;
          w_rsp_data_next   = {r_res, add_sdo};
        end else begin
          w_rsp_status_next = ST_TMO;
          w_rsp_data_next   = '0;
        end
      end
      S_RESP: if (w_state_next == S_IDLE) begin
        w_rsp_status_next = ST_OK;
        w_rsp_data_next   = '0;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_status <= ST_OK;
      r_add_rst    <= 1'b1;
      r_add_go     <= 1'b1;
      r_add_sdi    <= 1'b0;
    end else begin
      r_req_ready  <= w_req_ready_next;
      r_rsp_valid  <= w_rsp_valid_next;
      r_rsp_data   <= w_rsp_data_next;
      r_rsp_status <= w_rsp_status_next;
      r_add_rst    <= w_add_rst_next;
      r_add_go     <= w_add_go_next;
      r_add_sdi    <= w_add_sdi_next;
    end
  end

  // Phase counters: cleared on every state change, advanced only where they are used
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt  <= '0;
      r_lead_cnt <= '0;
      r_tmo_cnt  <= '0;
    end else if (w_state_next != r_state) begin
      r_bit_cnt  <= '0;
      r_lead_cnt <= '0;
      r_tmo_cnt  <= '0;
    end else begin
      if (r_state == S_SEND || r_state == S_RECV) r_bit_cnt <= r_bit_cnt + 7'd1;
      if (r_state == S_GO) r_lead_cnt <= r_lead_cnt + 4'd1;
      if (r_state == S_RST || r_state == S_ARM || r_state == S_WAIT) r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end

  // Operand shifter (shifts as each bit is launched) and result collector
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shreg <= '0;
      r_res   <= '0;
    end else begin
      if (r_state == S_IDLE && req_valid && r_req_ready) r_shreg <= {op_a, op_b};
      else if (w_state_next == S_SEND)                   r_shreg <= {r_shreg[62:0], 1'b0};
      if ((r_state == S_WAIT || r_state == S_RECV) && add_done) r_res <= {r_res[29:0], add_sdo};
    end
  end

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_status = r_rsp_status;
  assign add_rst    = r_add_rst;
  assign add_go     = r_add_go;
  assign add_sdi    = r_add_sdi;

endmodule
